instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of decode and directly consuming the memory's combinational instruction port.
- Drives the 12-bit byte instruction address and captures the returned 16-bit word with its PC into a small prefetch queue.
- Presents the queue head to decode with a valid/ready handshake and accepts PC redirects (branch/jump resolution) from execute.

Parameters:
- ADDR_W, 12, byte address width (memory word index is addr[ADDR_W-3:1] within the selected bank)
- DATA_W, 16, instruction width
- RESET_PC, 12'h000, byte address fetched first after reset (bit 0 ignored)
- QDEPTH, 2, prefetch queue entries (power of two, 2..8)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  ADDR_W  instruction address to memory, always even
- imem_data  in  DATA_W  instruction word, combinational from imem_addr in the same cycle
- redirect_valid  in  1  one-cycle pulse: discard queue, restart fetch at redirect_addr
- redirect_addr  in  ADDR_W  new fetch byte address (bit 0 forced to 0)
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decode accepts head
- instr  out  DATA_W  head instruction word
- instr_pc  out  ADDR_W  byte address the head word was fetched from
- instr_predecoded  out  1  head was a jump already followed by fetch (0 unless macro defined)

Behaviour:
- Reset (synchronous, active-high): fetch_pc <= {RESET_PC[ADDR_W-1:1],0}; queue count <= 0; instr_valid=0, instr=0, instr_pc=0, instr_predecoded=0. Reset asserted mid-operation discards all entries and any in-flight redirect.
- imem_addr = fetch_pc (registered value, no combinational path from inputs).
- Per cycle: pop = instr_valid & instr_ready; push = !rst & !redirect_valid & (count < QDEPTH | pop).
- On push: enqueue {imem_data, fetch_pc}; fetch_pc <= fetch_pc + 2, modulo 2^ADDR_W (12'hFFE wraps to 12'h000).
- Full queue with no pop: no push, fetch_pc holds, imem_addr stable.
- Simultaneous push and pop at full: both occur, count unchanged.
- Empty queue: instr_valid=0; instr, instr_pc, instr_predecoded forced to 0.
- First word appears at the outputs one cycle after it is addressed (registered queue; latency from fetch_pc change to instr_valid = 1 cycle).
- Redirect priority: on redirect_valid, a pop in the same cycle still completes (decode owns that word); all remaining entries are discarded (count <= 0); fetch_pc <= {redirect_addr[ADDR_W-1:1],0}; no push. instr_valid=0 the following cycle and the redirect target word is valid the cycle after (2-cycle redirect bubble).
- Back-to-back redirects: the last one wins; every redirect restarts the bubble.
- Queue implemented as circular buffer with rd/wr pointers wrapping at QDEPTH; count in 0..QDEPTH.

Optional Feature:
- Macro JUMP_PREDECODE_EN.
- Defined: a pushed word with imem_data[15:12]==4'hF (JMP) sets fetch_pc <= {imem_data[10:0],1'b0} instead of fetch_pc+2. The entry is stored with predecoded=1 and still delivered to decode; execute does not redirect for predecoded jumps. An external redirect in the same cycle still wins.
- Not defined: fetch is strictly sequential and instr_predecoded is tied 0.

Test Plan:
- Reset with RESET_PC=0, memory words 0x1111@0, 0x2222@2, instr_ready=1 -> cycle 1 instr=0x1111 pc=0x000; cycle 2 instr=0x2222 pc=0x002; imem_addr steps 0,2,4.
- instr_ready=0 for 5 cycles -> queue fills to 2, imem_addr holds at 0x004, instr stays 0x1111; release -> 0x1111, 0x2222, then word@0x004 with no gap or duplicate.
- redirect_valid pulse with redirect_addr=0x191 while head valid and ready=1 -> head accepted; next cycle instr_valid=0; following cycle instr_pc=0x190.
- Start at RESET_PC=0xFFC -> pcs delivered in order 0xFFC, 0xFFE, 0x000.
- Memory word 0xF0C8 at 0x000 with JUMP_PREDECODE_EN -> imem_addr goes 0x000 then 0x190; instr 0xF0C8 delivered with instr_predecoded=1. Without the macro, imem_addr goes 0x002 and instr_predecoded=0.
- rst asserted for one cycle while queue holds 2 entries -> next cycle instr_valid=0 and imem_addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: drives the combinational instruction memory port and buffers
// {word, pc} pairs in a small circular prefetch queue for decode. Optional: JUMP_PREDECODE_EN.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 12'h000,
  parameter int                QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_predecoded
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(QDEPTH);

  logic [ADDR_W-1:0] fetch_pc, next_pc;
  logic [DATA_W-1:0] q_data [QDEPTH];
  logic [ADDR_W-1:0] q_pc   [QDEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              pop, push;
  logic              unused_bits;

  assign unused_bits = redirect_addr[0];
  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;
  assign push        = !rst & !redirect_valid & ((count < FULL) | pop);

`ifdef JUMP_PREDECODE_EN
  // A JMP word steers fetch straight to its target; decode still sees the word.
  logic jmp;
  logic q_pd [QDEPTH];
  assign jmp     = (imem_data[DATA_W-1:DATA_W-4] == 4'hF);
  assign next_pc = jmp ? {imem_data[ADDR_W-2:0], 1'b0} : fetch_pc + ADDR_W'(2);

  always_ff @(posedge clk) begin
    if (push) q_pd[wr_ptr] <= jmp;
  end

  assign instr_predecoded = instr_valid ? q_pd[rd_ptr] : 1'b0;
`else
  assign next_pc          = fetch_pc + ADDR_W'(2);
  assign instr_predecoded = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= {RESET_PC[ADDR_W-1:1], 1'b0};
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_valid) begin
      // Any same-cycle pop is implicitly honoured: the whole queue is dropped anyway.
      fetch_pc <= {redirect_addr[ADDR_W-1:1], 1'b0};
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (push) begin
        fetch_pc <= next_pc;
        wr_ptr   <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= imem_data;
      q_pc[wr_ptr]   <= fetch_pc;
    end
  end

  assign instr    = instr_valid ? q_data[rd_ptr] : '0;
  assign instr_pc = instr_valid ? q_pc[rd_ptr]   : '0;

endmodule
